tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter W, default 8, data width of one channel word.
REQ-002 Parameter N, default 4, number of channels (slots per frame); legal range 2..16.
REQ-003 clk  input  1  the only clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_sof  input  1  beat is slot 0 of a frame (start of frame); meaningful only with in_valid.
REQ-007 in_data  input  W  beat payload.
REQ-008 in_ready  output  1  block accepts beat this cycle; a beat transfers when in_valid and in_ready are both 1.
REQ-009 out_valid  output  N  per-channel word-held flag.
REQ-010 out_data  output  N*W  per-channel word; channel k occupies bits [k*W+W-1 : k*W].
REQ-011 out_ready  input  N  per-channel consumer accept; a word drains when out_valid[k] and out_ready[k] are both 1.
REQ-012 frame_err  output  1  one-cycle pulse on a framing violation.
REQ-013 frame_cnt  output  8  count of completed frames.

Function
REQ-014 Block SHALL be the receive end of a time-division multiplexed stream: the serial beat in slot k is routed to channel k.
REQ-015 Block SHALL keep a two-state FSM, HUNT and LOCK, and a slot counter over 0..N-1.
REQ-016 Target channel tgt SHALL be 0 when in_sof=1, else the slot counter.
REQ-017 in_ready SHALL be combinational: 1 when a beat is to be dropped (REQ-018, REQ-021), else (!out_valid[tgt] || out_ready[tgt]).
REQ-018 HUNT: beats with in_sof=0 SHALL be accepted and dropped, with no frame_err.
REQ-019 HUNT: an accepted beat with in_sof=1 SHALL be stored to channel 0, set slot to 1, and enter LOCK.
REQ-020 LOCK: an accepted beat with in_sof=0 and slot!=0 SHALL be stored to channel slot and increment slot, wrapping N-1 to 0.
REQ-021 LOCK: a beat with in_sof=0 at slot 0 SHALL be accepted and dropped, pulse frame_err, and return to HUNT with slot 0.
REQ-022 LOCK: an accepted beat with in_sof=1 at slot!=0 SHALL pulse frame_err, be stored to channel 0, set slot to 1, and remain in LOCK (resync); in_sof=1 at slot 0 is normal and raises no error.
REQ-023 A stored word SHALL appear on out_data/out_valid of its channel the cycle after acceptance (latency 1).
REQ-024 out_valid[k] and out_data[k] SHALL hold stable until drained; a drain without a new write clears out_valid[k] and leaves out_data[k] unchanged.
REQ-025 A simultaneous drain and write on one channel SHALL load the new word with out_valid[k] staying 1.
REQ-026 A backpressured beat (in_valid=1, in_ready=0) SHALL change no state; the slot does not advance.
REQ-027 frame_cnt SHALL increment by 1 when a beat is stored to slot N-1, wrapping 255 to 0.
REQ-028 frame_err SHALL be registered, high for exactly one cycle per violation.

Reset
REQ-029 While rst=1, independent of clk: FSM=HUNT, slot=0, out_valid=0, out_data=0, frame_err=0, frame_cnt=0.
REQ-030 Reset asserted mid-frame SHALL discard held words and the partial frame; after release the block requires an in_sof beat before storing data.

Verification
REQ-031 N=4, out_ready all 1, beats sof=1 0xA0, then 0xA1, 0xA2, 0xA3 -> channels 0..3 show 0xA0..0xA3 one cycle after each beat; frame_cnt 0->1; frame_err never high.
REQ-032 From reset, two beats with sof=0 then a sof frame -> first two dropped with in_ready=1, no frame_err; frame delivered as in REQ-031.
REQ-033 After 0xB0 (sof), 0xB1, an in_sof=1 beat 0xC0 -> frame_err one-cycle pulse; channel 0=0xC0; next beat goes to channel 1; frame_cnt unchanged.
REQ-034 out_ready[2]=0 with channel 2 holding 0x55; next frame's slot-2 beat -> in_ready=0, beat held, slot stays 2; raising out_ready[2] -> beat accepted, channel 2 shows the new word next cycle.
REQ-035 Frame complete, next beat has in_sof=0 at slot 0 -> frame_err pulse, FSM returns to HUNT, and subsequent non-sof beats are dropped.
REQ-036 256 complete frames -> frame_cnt wraps to 0; rst pulse asserted mid-frame -> all outputs zero immediately without a clock edge.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Handshake and output bundle for the TDM receive block.
// master = stream source/consumers side, slave = tdm_demux.
interface tdm_demux_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic           in_valid;
  logic           in_sof;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ready;
  logic           frame_err;
  logic [7:0]     frame_cnt;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive end: routes the beat in slot k of each frame to channel k,
// tracking frame alignment with a HUNT/LOCK FSM.
//   state | meaning
//   HUNT  | not aligned; non-sof beats are dropped until an in_sof beat arrives
//   LOCK  | aligned; r_slot is the channel the next non-sof beat belongs to
module tdm_demux #(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic          clk,
  input logic          rst,
  tdm_demux_if.slave   io_bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {HUNT, LOCK} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_slot;
  logic [N-1:0]   r_valid;
  logic [N*W-1:0] r_data;
  logic           r_err;
  logic [7:0]     r_fcnt;

  logic [SW-1:0]  w_tgt;
  logic           w_drop;
  logic           w_ready;
  logic           w_acc;
  logic           w_store;
  logic           w_last;

  always_comb begin
    w_tgt   = io_bus.in_sof ? '0 : r_slot;
    // In HUNT the slot is always 0, so one test covers both drop cases
    w_drop  = !io_bus.in_sof && ((r_state == HUNT) || (r_slot == '0));
    w_ready = w_drop || !r_valid[w_tgt] || io_bus.out_ready[w_tgt];
    w_acc   = io_bus.in_valid && w_ready;
    w_store = w_acc && !w_drop;
    w_last  = (w_tgt == SW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_slot  <= '0;
      r_valid <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_fcnt  <= 8'd0;
    end else begin
      r_err <= 1'b0;
      for (int k = 0; k < N; k++) begin
        if (io_bus.out_ready[k]) r_valid[k] <= 1'b0;
      end
      if (w_store) begin
        r_valid[w_tgt]                <= 1'b1;
        r_data[int'(w_tgt) * W +: W]  <= io_bus.in_data;
      end
      if (w_acc) begin
        if (w_drop) begin
          if (r_state == LOCK) r_err <= 1'b1;
          r_state <= HUNT;
          r_slot  <= '0;
        end else begin
          // sof arriving mid-frame: resync onto it, but flag the violation
          if (io_bus.in_sof && (r_state == LOCK) && (r_slot != '0)) r_err <= 1'b1;
          r_state <= LOCK;
          if (w_last) begin
            r_slot <= '0;
            r_fcnt <= r_fcnt + 8'd1;
          end else begin
            r_slot <= w_tgt + 1'b1;
          end
        end
      end
    end
  end

  assign io_bus.in_ready  = w_ready;
  assign io_bus.out_valid = r_valid;
  assign io_bus.out_data  = r_data;
  assign io_bus.frame_err = r_err;
  assign io_bus.frame_cnt = r_fcnt;
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frame scenarios plus randomized
// traffic, all compared every cycle against a frame-position model.
module tb_tdm_demux;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_if #(.W(W), .N(N)) bus ();

  tdm_demux #(.W(W), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: m_pos = -1 when not aligned, else the slot of the next expected beat
  int             m_pos;
  logic [N-1:0]   m_valid;
  logic [N*W-1:0] m_data;
  logic           m_err;
  int             m_fcnt;
  logic           obs_rdy;
  int             gp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_valid = '0; m_data = '0; m_err = 1'b0; m_fcnt = 0;
  endtask

  task automatic store(input int c, input logic [W-1:0] d);
    m_valid[c] = 1'b1;
    m_data[c*W +: W] = d;
  endtask

  task automatic cycle(input bit v, input bit s, input logic [W-1:0] d, input logic [N-1:0] ordy);
    int tgt;
    bit drop, rdy;
    @(negedge clk);
    bus.in_valid = v; bus.in_sof = s; bus.in_data = d; bus.out_ready = ordy;
    #2;
    tgt  = s ? 0 : m_pos;
    drop = !s && (m_pos <= 0);
    rdy  = drop ? 1'b1 : (!m_valid[tgt] || ordy[tgt]);
    obs_rdy = bus.in_ready;
    chk("in_ready", 32'(obs_rdy), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data", bus.out_data, m_data);
    chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
    m_valid = m_valid & ~ordy;
    m_err = 1'b0;
    if (v && rdy) begin
      if (s) begin
        if (m_pos > 0) m_err = 1'b1;
        store(0, d);
        m_pos = 1;
      end else if (m_pos <= 0) begin
        m_err = (m_pos == 0);
        m_pos = -1;
      end else begin
        store(m_pos, d);
        if (m_pos == N - 1) begin
          m_fcnt = (m_fcnt + 1) % 256;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_err"}, 32'(bus.frame_err), 0);
    chk({tag, "_cnt"}, 32'(bus.frame_cnt), 0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    gp = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) cycle(1'b1, i == 0, base + W'(i), '1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.out_ready = '1;
    model_reset();
    gp = 0;
    #3 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Non-sof beats before alignment are dropped silently
    cycle(1, 0, 8'h11, 4'hF);
    chk("hunt_drop_rdy", 32'(obs_rdy), 1);
    chk("hunt_drop_err", 32'(bus.frame_err), 0);
    cycle(1, 0, 8'h12, 4'hF);
    chk("hunt_drop_valid", 32'(bus.out_valid), 0);

    // Basic frame A0..A3
    cycle(1, 1, 8'hA0, 4'hF);
    chk("ch0_A0", 32'(bus.out_data[7:0]), 32'hA0);
    chk("ch0_valid", 32'(bus.out_valid), 32'h1);
    cycle(1, 0, 8'hA1, 4'hF);
    chk("ch1_A1", 32'(bus.out_data[15:8]), 32'hA1);
    cycle(1, 0, 8'hA2, 4'hF);
    chk("ch2_A2", 32'(bus.out_data[23:16]), 32'hA2);
    chk("fcnt_before", 32'(bus.frame_cnt), 0);
    cycle(1, 0, 8'hA3, 4'hF);
    chk("ch3_A3", 32'(bus.out_data[31:24]), 32'hA3);
    chk("fcnt_1", 32'(bus.frame_cnt), 1);

    // Mid-frame sof: resync with error pulse
    cycle(1, 1, 8'hB0, 4'hF);
    cycle(1, 0, 8'hB1, 4'hF);
    cycle(1, 1, 8'hC0, 4'hF);
    chk("resync_err", 32'(bus.frame_err), 1);
    chk("resync_ch0", 32'(bus.out_data[7:0]), 32'hC0);
    chk("resync_fcnt", 32'(bus.frame_cnt), 1);
    cycle(1, 0, 8'hD1, 4'hF);
    chk("resync_err_pulse", 32'(bus.frame_err), 0);
    chk("resync_ch1", 32'(bus.out_data[15:8]), 32'hD1);
    cycle(1, 0, 8'hD2, 4'hF);
    cycle(1, 0, 8'hD3, 4'hF);
    chk("fcnt_2", 32'(bus.frame_cnt), 2);

    // Backpressure on channel 2
    cycle(1, 1, 8'hE0, 4'hF);
    cycle(1, 0, 8'hE1, 4'hF);
    cycle(1, 0, 8'h55, 4'b1011);
    cycle(1, 0, 8'hE3, 4'b1011);
    cycle(1, 1, 8'hF0, 4'b1011);
    cycle(1, 0, 8'hF1, 4'b1011);
    cycle(1, 0, 8'hF2, 4'b1011);
    chk("bp_rdy", 32'(obs_rdy), 0);
    chk("bp_hold", 32'(bus.out_data[23:16]), 32'h55);
    cycle(1, 0, 8'hF2, 4'b1011);
    chk("bp_rdy2", 32'(obs_rdy), 0);
    cycle(1, 0, 8'hF2, 4'hF);
    chk("bp_release_rdy", 32'(obs_rdy), 1);
    chk("bp_release_ch2", 32'(bus.out_data[23:16]), 32'hF2);
    chk("bp_release_v2", 32'(bus.out_valid[2]), 1);
    cycle(1, 0, 8'hF3, 4'hF);
    chk("fcnt_4", 32'(bus.frame_cnt), 4);

    // Missing sof at frame boundary: error then back to hunting
    cycle(1, 0, 8'h99, 4'hF);
    chk("nosof_err", 32'(bus.frame_err), 1);
    cycle(1, 0, 8'h9A, 4'hF);
    chk("hunt_again_rdy", 32'(obs_rdy), 1);
    chk("hunt_again_err", 32'(bus.frame_err), 0);
    chk("hunt_again_valid", 32'(bus.out_valid), 0);
    chk("hunt_again_ch1", 32'(bus.out_data[15:8]), 32'hF1);

    // Randomized traffic with occasional framing faults and backpressure
    for (int c = 0; c < 3000; c++) begin
      bit v, s;
      logic [N-1:0] r;
      if (c == 1500) do_reset("mid_reset");
      v = ($urandom_range(0, 9) < 8);
      s = (gp == 0) ^ ($urandom_range(0, 99) < 6);
      for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 3) != 0);
      cycle(v, s, W'($urandom), r);
      if (v && obs_rdy) gp = s ? 1 : (gp + 1) % N;
    end

    // Frame counter wrap
    do_reset("pre_wrap");
    for (int f = 0; f < 255; f++) frame(W'(f));
    chk("fcnt_255", 32'(bus.frame_cnt), 255);
    frame(8'h70);
    chk("fcnt_wrap", 32'(bus.frame_cnt), 0);

    // Reset mid-frame discards the partial frame; sof required afterwards
    cycle(1, 1, 8'h30, 4'h0);
    cycle(1, 0, 8'h31, 4'h0);
    do_reset("async_mid");
    cycle(1, 0, 8'h32, 4'hF);
    chk("post_rst_drop_valid", 32'(bus.out_valid), 0);
    chk("post_rst_drop_err", 32'(bus.frame_err), 0);
    cycle(1, 1, 8'h40, 4'hF);
    chk("post_rst_sof", 32'(bus.out_data[7:0]), 32'h40);
    cycle(0, 0, 8'h00, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
